// File: rtl/key_direction_decoder.sv
// key_direction_decoder: PS/2 scan-code parser driving four players' pending/committed directions.
// Define REVERSE_BLOCK_EN to drop makes that would reverse a player's effective heading.
module key_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    input  logic       clear,
    input  logic [3:0] dir_ack,
    output logic [3:0] dir_valid,
    output logic [7:0] dir_pending,
    output logic [7:0] dir_current
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CUR_INIT = 8'b10_11_00_01;
`ifdef REVERSE_BLOCK_EN
    localparam bit REV_BLOCK = 1'b1;
`else
    localparam bit REV_BLOCK = 1'b0;
`endif
    state_t state;
    logic [CW-1:0] cnt;
    logic hit, make_ok;
    logic [1:0] player, dir;
    logic [3:0] commit, accept;
    logic [7:0] eff;
    // Map a scan code to its player and direction
    always_comb begin
        hit = 1'b1;
        player = 2'd0;
        dir = 2'd0;
        case (ps2_key_data)
            8'h1C: {player, dir} = {2'd0, 2'd0};
            8'h23: {player, dir} = {2'd0, 2'd1};
            8'h1D: {player, dir} = {2'd0, 2'd2};
            8'h1B: {player, dir} = {2'd0, 2'd3};
            8'h2B: {player, dir} = {2'd1, 2'd0};
            8'h33: {player, dir} = {2'd1, 2'd1};
            8'h2C: {player, dir} = {2'd1, 2'd2};
            8'h34: {player, dir} = {2'd1, 2'd3};
            8'h3B: {player, dir} = {2'd2, 2'd0};
            8'h4B: {player, dir} = {2'd2, 2'd1};
            8'h43: {player, dir} = {2'd2, 2'd2};
            8'h42: {player, dir} = {2'd2, 2'd3};
            8'h6B: {player, dir} = {2'd3, 2'd0};
            8'h74: {player, dir} = {2'd3, 2'd1};
            8'h75: {player, dir} = {2'd3, 2'd2};
            8'h73: {player, dir} = {2'd3, 2'd3};
            default: hit = 1'b0;
        endcase
        make_ok = ps2_key_pressed && hit &&
                  ((state == IDLE && ps2_key_data != 8'hF0 && ps2_key_data != 8'hE0) ||
                   (state == EXT && ps2_key_data != 8'hF0 && player == 2'd3));
    end
    // Per-player acceptance against the heading as it stands after any same-cycle commit
    always_comb begin
        commit = '0;
        accept = '0;
        eff = '0;
        for (int p = 0; p < 4; p++) begin
            commit[p] = dir_ack[p] & dir_valid[p];
            eff[2*p +: 2] = commit[p] ? dir_pending[2*p +: 2] : dir_current[2*p +: 2];
            accept[p] = make_ok && player == p[1:0] &&
                        !((!dir_valid[p] || commit[p]) && dir == eff[2*p +: 2]) &&
                        !(REV_BLOCK && dir == (eff[2*p +: 2] ^ 2'b01));
        end
    end
    // Prefix parser with idle timeout back to IDLE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
        end else if (clear) begin
            state <= IDLE;
            cnt <= '0;
        end else if (ps2_key_pressed) begin
            cnt <= '0;
            state <= state == IDLE ? (ps2_key_data == 8'hF0 ? BRK : ps2_key_data == 8'hE0 ? EXT : IDLE) :
                     state == EXT  ? (ps2_key_data == 8'hF0 ? EXT_BRK : IDLE) : IDLE;
        end else if (state != IDLE) begin
            state <= cnt == LAST ? IDLE : state;
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
        end
    end
    // Pending/commit bookkeeping, players independent
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dir_valid <= '0;
            dir_pending <= '0;
            dir_current <= CUR_INIT;
        end else if (clear) begin
            dir_valid <= '0;
            dir_pending <= '0;
            dir_current <= CUR_INIT;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (accept[p]) begin
                    dir_pending[2*p +: 2] <= dir;
                    dir_valid[p] <= 1'b1;
                end else if (commit[p]) begin
                    dir_valid[p] <= 1'b0;
                end
                if (commit[p]) dir_current[2*p +: 2] <= dir_pending[2*p +: 2];
            end
        end
    end
endmodule
